// File: rtl/game_pkg.sv
// Shared game-flow definitions: state encoding, tuning constants and LFSR setup.
// Imported by the scheduler, the renderer and the collision checker.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  localparam int SPAWN_X      = 400;
  localparam int MIN_GAP      = 40;
  localparam int GAP_MASK     = 63;
  localparam int SPEED_INIT   = 3;
  localparam int SPEED_STEP   = 2;
  localparam int SPEED_MAX    = 20;
  localparam int LEVEL_FRAMES = 1024;

  // Galois form of x^16+x^14+x^13+x^11; a non-zero seed keeps it off the all-zero state.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances on every game_clk edge regardless of game state.
module lfsr16
  import game_pkg::*;
(
  input  logic        game_clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge game_clk or negedge rst_n) begin
    if (!rst_n) q <= LFSR_SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game-flow controller: IDLE/RUN/OVER sequencing, obstacle slot pool, spawn gaps,
// per-level speed ramp and night toggle. One game_clk edge is one frame.
module obstacle_scheduler #(
  parameter int SLOTS        = 3,
  parameter int X_W          = 12,
  parameter int SPAWN_X      = game_pkg::SPAWN_X,
  parameter int MIN_GAP      = game_pkg::MIN_GAP,
  parameter int GAP_MASK     = game_pkg::GAP_MASK,
  parameter int SPEED_INIT   = game_pkg::SPEED_INIT,
  parameter int SPEED_STEP   = game_pkg::SPEED_STEP,
  parameter int SPEED_MAX    = game_pkg::SPEED_MAX,
  parameter int LEVEL_FRAMES = game_pkg::LEVEL_FRAMES
) (
  input  logic                 game_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 collided,
  output logic [SLOTS-1:0]     obs_valid,
  output logic [SLOTS*X_W-1:0] obs_x,
  output logic [SLOTS-1:0]     obs_kind,
  output logic [4:0]           obs_speed,
  output logic                 running,
  output logic                 game_over,
  output logic                 night,
  output logic [15:0]          score
);

  localparam int LVL_W = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;
  localparam logic [LVL_W-1:0] LVL_LAST   = LVL_W'(LEVEL_FRAMES - 1);
  localparam logic [X_W-1:0]   SPAWN_XV   = X_W'(SPAWN_X);
  localparam logic [15:0]      GAP_MIN16  = 16'(MIN_GAP);
  localparam logic [15:0]      GAP_MASK16 = 16'(GAP_MASK);
  localparam logic [4:0]       SPD_INIT5  = 5'(SPEED_INIT);
  localparam logic [5:0]       SPD_STEP6  = 6'(SPEED_STEP);
  localparam logic [5:0]       SPD_MAX6   = 6'(SPEED_MAX);

  game_pkg::game_state_e state_q, state_d;

  logic [SLOTS-1:0]          valid_q, valid_d;
  logic [SLOTS-1:0][X_W-1:0] x_q, x_d;
  logic [SLOTS-1:0]          kind_q, kind_d;
  logic [4:0]                speed_q, speed_d;
  logic                      night_q, night_d;
  logic [15:0]               score_q, score_d;
  logic [15:0]               gap_q, gap_d;
  logic [LVL_W-1:0]          level_q, level_d;
  logic [15:0]               lfsr_q;
  logic [5:0]                speed_sum;
  logic                      spawned;

  lfsr16 u_lfsr (
    .game_clk (game_clk),
    .rst_n    (rst_n),
    .q        (lfsr_q)
  );

  always_ff @(posedge game_clk or negedge rst_n) begin
    if (!rst_n) state_q <= game_pkg::ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    x_d       = x_q;
    kind_d    = kind_q;
    speed_d   = speed_q;
    night_d   = night_q;
    score_d   = score_q;
    gap_d     = gap_q;
    level_d   = level_q;
    spawned   = 1'b0;
    speed_sum = {1'b0, speed_q} + SPD_STEP6;

    unique case (state_q)
      game_pkg::ST_IDLE, game_pkg::ST_OVER: begin
        if (start) begin
          state_d = game_pkg::ST_RUN;
          valid_d = '0;
          x_d     = {SLOTS{SPAWN_XV}};
          kind_d  = '0;
          speed_d = SPD_INIT5;
          night_d = 1'b0;
          score_d = '0;
          gap_d   = GAP_MIN16;
          level_d = '0;
        end
      end

      game_pkg::ST_RUN: begin
        if (collided) begin
          state_d = game_pkg::ST_OVER;
        end else begin
          // Retire instead of moving when the step would cross x=0.
          for (int i = 0; i < SLOTS; i++) begin
            if (valid_q[i]) begin
              if ($signed(x_q[i]) < $signed(X_W'(speed_q))) valid_d[i] = 1'b0;
              else                                          x_d[i]     = x_q[i] - X_W'(speed_q);
            end
          end

          // Free slots are judged on start-of-cycle validity, so a slot
          // retired on this edge only becomes reusable on the next one.
          if (gap_q != 16'd0) begin
            gap_d = gap_q - 16'd1;
          end else begin
            for (int i = 0; i < SLOTS; i++) begin
              if (!valid_q[i] && !spawned) begin
                spawned    = 1'b1;
                valid_d[i] = 1'b1;
                x_d[i]     = SPAWN_XV;
                kind_d[i]  = lfsr_q[0];
              end
            end
            if (spawned) gap_d = GAP_MIN16 + (lfsr_q & GAP_MASK16);
          end

          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;

          if (level_q == LVL_LAST) begin
            level_d = '0;
            speed_d = (speed_sum > SPD_MAX6) ? SPD_MAX6[4:0] : speed_sum[4:0];
            night_d = ~night_q;
          end else begin
            level_d = level_q + 1'b1;
          end
        end
      end

      default: state_d = game_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge game_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      x_q     <= {SLOTS{SPAWN_XV}};
      kind_q  <= '0;
      speed_q <= SPD_INIT5;
      night_q <= 1'b0;
      score_q <= '0;
      gap_q   <= GAP_MIN16;
      level_q <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      kind_q  <= kind_d;
      speed_q <= speed_d;
      night_q <= night_d;
      score_q <= score_d;
      gap_q   <= gap_d;
      level_q <= level_d;
    end
  end

  assign obs_valid = valid_q;
  assign obs_x     = x_q;
  assign obs_kind  = kind_q;
  assign obs_speed = speed_q;
  assign night     = night_q;
  assign score     = score_q;
  assign running   = (state_q == game_pkg::ST_RUN);
  assign game_over = (state_q == game_pkg::ST_OVER);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: three instances cover default tuning,
// a tight spawn gap (slot exhaustion) and a short level (speed ramp, collision).
module tb_obstacle_scheduler;

  logic game_clk;

  logic rst_n_a, start_a, collided_a;
  logic [2:0] valid_a, kind_a;
  logic [35:0] x_a;
  logic [4:0] speed_a;
  logic running_a, over_a, night_a;
  logic [15:0] score_a;

  logic rst_n_b, start_b, collided_b;
  logic [2:0] valid_b, kind_b;
  logic [35:0] x_b;
  logic [4:0] speed_b;
  logic running_b, over_b, night_b;
  logic [15:0] score_b;

  logic rst_n_c, start_c, collided_c;
  logic [2:0] valid_c, kind_c;
  logic [35:0] x_c;
  logic [4:0] speed_c;
  logic running_c, over_c, night_c;
  logic [15:0] score_c;

  logic [35:0] x_reset;
  logic [15:0] lfsr_m, lfsr_at_spawn;
  int n_checks = 0;
  int n_errors = 0;
  int gap_g;

  obstacle_scheduler dut_a (
    .game_clk(game_clk), .rst_n(rst_n_a), .start(start_a), .collided(collided_a),
    .obs_valid(valid_a), .obs_x(x_a), .obs_kind(kind_a), .obs_speed(speed_a),
    .running(running_a), .game_over(over_a), .night(night_a), .score(score_a)
  );

  obstacle_scheduler #(.MIN_GAP(1), .GAP_MASK(0)) dut_b (
    .game_clk(game_clk), .rst_n(rst_n_b), .start(start_b), .collided(collided_b),
    .obs_valid(valid_b), .obs_x(x_b), .obs_kind(kind_b), .obs_speed(speed_b),
    .running(running_b), .game_over(over_b), .night(night_b), .score(score_b)
  );

  obstacle_scheduler #(.LEVEL_FRAMES(8)) dut_c (
    .game_clk(game_clk), .rst_n(rst_n_c), .start(start_c), .collided(collided_c),
    .obs_valid(valid_c), .obs_x(x_c), .obs_kind(kind_c), .obs_speed(speed_c),
    .running(running_c), .game_over(over_c), .night(night_c), .score(score_c)
  );

  // clock / reset
  initial begin
    game_clk = 1'b0;
    forever #5 game_clk = ~game_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Reference LFSR tracking dut_a's reset domain
  always @(posedge game_clk or negedge rst_n_a) begin
    if (!rst_n_a) lfsr_m <= 16'hACE1;
    else          lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  // driver / checker tasks
  task automatic tick(input int n);
    repeat (n) @(posedge game_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [11:0] slot_x(input logic [35:0] v, input int i);
    return v[i*12 +: 12];
  endfunction

  initial begin
    x_reset = {12'd400, 12'd400, 12'd400};
    rst_n_a = 0; rst_n_b = 0; rst_n_c = 0;
    start_a = 0; start_b = 0; start_c = 0;
    collided_a = 0; collided_b = 0; collided_c = 0;
    tick(2);
    rst_n_a = 1; rst_n_b = 1; rst_n_c = 1;

    // reset values on dut_a
    check("rst_valid", valid_a, 0);
    check("rst_x", x_a, x_reset);
    check("rst_kind", kind_a, 0);
    check("rst_speed", speed_a, 3);
    check("rst_running", running_a, 0);
    check("rst_over", over_a, 0);
    check("rst_night", night_a, 0);
    check("rst_score", score_a, 0);

    // collided is ignored in IDLE
    collided_a = 1;
    tick(2);
    check("idle_collided_running", running_a, 0);
    check("idle_collided_over", over_a, 0);
    collided_a = 0;

    // start and first spawn with default tuning
    start_a = 1;
    tick(1);
    start_a = 0;
    check("start_running", running_a, 1);
    check("start_score", score_a, 0);
    tick(40);
    check("pre_spawn_valid", valid_a, 0);
    check("pre_spawn_score", score_a, 40);
    lfsr_at_spawn = lfsr_m;
    gap_g = 40 + int'(lfsr_at_spawn & 16'd63);
    tick(1);
    check("spawn_valid0", valid_a[0], 1);
    check("spawn_x0", slot_x(x_a, 0), 400);
    check("spawn_kind0", kind_a[0], lfsr_at_spawn[0]);
    for (int e = 42; e <= 175; e++) begin
      tick(1);
      if (e == 42) check("move_x0", slot_x(x_a, 0), 397);
      if (e == 41 + gap_g) check("gap_slot1_not_yet", valid_a[1], 0);
      if (e == 42 + gap_g) begin
        check("gap_slot1_spawn", valid_a[1], 1);
        check("gap_slot1_x", slot_x(x_a, 1), 400);
      end
      if (e == 174) begin
        check("pre_retire_valid0", valid_a[0], 1);
        check("pre_retire_x0", slot_x(x_a, 0), 1);
      end
      if (e == 175) begin
        check("retire_valid0", valid_a[0], 0);
        check("retire_x0_held", slot_x(x_a, 0), 1);
        check("retire_score", score_a, 175);
      end
    end

    // slot exhaustion: MIN_GAP=1, GAP_MASK=0
    start_b = 1;
    tick(1);
    start_b = 0;
    for (int e = 1; e <= 139; e++) begin
      tick(1);
      case (e)
        1: check("exh_e1", valid_b, 3'b000);
        2: check("exh_e2", valid_b, 3'b001);
        3: check("exh_e3", valid_b, 3'b001);
        4: check("exh_e4", valid_b, 3'b011);
        5: check("exh_e5", valid_b, 3'b011);
        6: check("exh_e6", valid_b, 3'b111);
        135: begin
          check("exh_e135_valid", valid_b, 3'b111);
          check("exh_e135_x0", slot_x(x_b, 0), 1);
        end
        136: begin
          check("exh_e136_valid", valid_b, 3'b110);
          check("exh_e136_x0", slot_x(x_b, 0), 1);
          check("exh_e136_x1", slot_x(x_b, 1), 4);
        end
        137: begin
          check("exh_e137_valid", valid_b, 3'b111);
          check("exh_e137_x0", slot_x(x_b, 0), 400);
          check("exh_e137_x1", slot_x(x_b, 1), 1);
        end
        138: begin
          check("exh_e138_valid", valid_b, 3'b101);
          check("exh_e138_x0", slot_x(x_b, 0), 397);
          check("exh_e138_x1", slot_x(x_b, 1), 1);
        end
        139: begin
          check("exh_e139_valid", valid_b, 3'b111);
          check("exh_e139_x1", slot_x(x_b, 1), 400);
        end
        default: ;
      endcase
    end

    // asynchronous reset mid-run with two slots valid
    rst_n_b = 0;
    tick(1);
    rst_n_b = 1;
    start_b = 1;
    tick(1);
    start_b = 0;
    tick(4);
    check("midrun_two_slots", valid_b, 3'b011);
    #2;
    rst_n_b = 0;
    #1;
    check("async_rst_valid", valid_b, 0);
    check("async_rst_x", x_b, x_reset);
    check("async_rst_kind", kind_b, 0);
    check("async_rst_speed", speed_b, 3);
    check("async_rst_running", running_b, 0);
    check("async_rst_over", over_b, 0);
    check("async_rst_night", night_b, 0);
    check("async_rst_score", score_b, 0);
    tick(1);
    rst_n_b = 1;
    tick(2);
    check("post_rst_idle", running_b, 0);

    // collision on a level boundary (LEVEL_FRAMES=8)
    start_c = 1;
    tick(1);
    start_c = 0;
    tick(40);
    check("lvl_e40_speed", speed_c, 13);
    check("lvl_e40_night", night_c, 1);
    tick(1);
    check("lvl_spawn_x0", slot_x(x_c, 0), 400);
    tick(6);
    check("lvl_e47_x0", slot_x(x_c, 0), 322);
    collided_c = 1;
    tick(1);
    check("col_over", over_c, 1);
    check("col_running", running_c, 0);
    check("col_speed", speed_c, 13);
    check("col_night", night_c, 1);
    check("col_x0", slot_x(x_c, 0), 322);
    check("col_valid", valid_c, 3'b001);
    check("col_score", score_c, 47);
    tick(3);
    check("over_hold_score", score_c, 47);
    check("over_hold_x0", slot_x(x_c, 0), 322);
    collided_c = 0;

    // restart from OVER, then speed ramp and saturation; start stays high briefly
    start_c = 1;
    tick(1);
    check("restart_running", running_c, 1);
    check("restart_over", over_c, 0);
    check("restart_valid", valid_c, 0);
    check("restart_score", score_c, 0);
    check("restart_speed", speed_c, 3);
    check("restart_night", night_c, 0);
    tick(2);
    start_c = 0;
    tick(5);
    check("ramp_e7_speed", speed_c, 3);
    check("ramp_e7_night", night_c, 0);
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) tick(1);
      else        tick(8);
      check("ramp_speed", speed_c, (3 + 2 * k > 20) ? 20 : 3 + 2 * k);
      check("ramp_night", night_c, k % 2);
      check("ramp_score", score_c, 8 * k);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Game-flow controller that sequences a run and schedules obstacles for the renderer and the collision logic. It owns the IDLE/RUN/OVER state machine and a small pool of obstacle slots. Spawn gaps come from an LFSR, and a per-level timer steps up the scroll speed and toggles night mode. It sits between the player inputs and the collision checker on the game clock, which ticks once per frame at about 60 Hz.

Parameters:
SLOTS, 3, number of concurrent obstacle slots
X_W, 12, signed width of obstacle x
SPAWN_X, 400, x loaded into a newly spawned slot
MIN_GAP, 40, minimum frames between spawns
GAP_MASK, 63, mask applied to the LFSR for the random extra gap
SPEED_INIT, 3, scroll speed at run start, in px/frame
SPEED_STEP, 2, speed increment per level
SPEED_MAX, 20, speed saturation value
LEVEL_FRAMES, 1024, frames per level

Ports:
game_clk  in  1  frame clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level-sampled start request
collided  in  1  collision flag from the collision checker
obs_valid  out  SLOTS  per-slot active flag
obs_x  out  SLOTS*X_W  per-slot signed x; slot i is at [i*X_W +: X_W]
obs_kind  out  SLOTS  per-slot sprite select: 0 = small, 1 = large
obs_speed  out  5  current scroll speed
running  out  1  high in RUN
game_over  out  1  high in OVER
night  out  1  day/night select
score  out  16  frames survived in the current run

Behaviour:
- Clock and reset: single clock game_clk; rst_n is asynchronous, active-low.
- Reset values: state IDLE, all obs_valid 0, obs_x all SPAWN_X, obs_kind 0, obs_speed SPEED_INIT, running 0, game_over 0, night 0, score 0, gap_cnt MIN_GAP, level_cnt 0, LFSR 16'hACE1.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every cycle in every state and never reaches 0.
- IDLE:
  - start=1 at an edge: go to RUN and (re)initialise the run.
  - Run init: slots cleared, speed SPEED_INIT, gap_cnt MIN_GAP, score 0, level_cnt 0, night 0, game_over 0.
  - collided is ignored.
- RUN, priority order per edge:
  1. collided=1: go to OVER and set game_over. Slots, speed, score, night and level_cnt freeze on this edge. No move, spawn or level update happens.
  2. Otherwise, move each valid slot: x <= x - speed. A slot whose current x < speed is instead retired: valid <= 0, x held.
  3. Spawn:
     - If gap_cnt != 0, decrement it.
     - Else if any slot was invalid at the start of this cycle, load the lowest-index such slot: valid 1, x SPAWN_X, kind = lfsr[0]. Reload gap_cnt = MIN_GAP + (lfsr & GAP_MASK).
     - Else hold gap_cnt at 0 and retry next cycle.
     - A slot retired this cycle is not reusable until the next cycle.
  4. score increments, saturating at 16'hFFFF.
  5. level_cnt increments. When it equals LEVEL_FRAMES-1 it wraps to 0, speed <= min(speed+SPEED_STEP, SPEED_MAX), and night toggles.
  6. start is ignored in RUN.
- OVER: outputs hold. start=1 re-initialises the run exactly as from IDLE and goes to RUN.
- Arithmetic: x subtraction in X_W-bit signed. Speed add computed in 6 bits before clamping. A freshly spawned slot does not move on its spawn edge.
- Reset mid-run: immediate return to reset values, no residual slots.

Decomposition:
- Shared package game_pkg holds:
  - state encoding ST_IDLE/ST_RUN/ST_OVER
  - SPAWN_X, MIN_GAP, GAP_MASK, SPEED_INIT/STEP/MAX, LEVEL_FRAMES
  - LFSR seed and taps
- The renderer and collision checker import the same package.
- One sub-module: lfsr16. Ports game_clk, rst_n, q[15:0]; free-running, seed from the package.

Test Plan:
- Reset: assert rst_n=0 mid-RUN with 2 slots valid -> all outputs at reset values asynchronously, state IDLE.
- Start and first spawn: start for 1 cycle -> running=1 next edge; obs_valid[0] rises on the 41st edge after start is sampled with x=400; x=397 on the 42nd edge.
- Retire: single slot from x=400 at speed 3 -> reaches x=1 after 133 moves; valid drops on the next edge, x stays 1.
- Slot exhaustion: MIN_GAP=1, GAP_MASK=0 -> slots 0, 1, 2 fill on alternate edges; gap_cnt holds 0 while full; the first freed slot is reloaded one edge after its retirement.
- Level and saturation: LEVEL_FRAMES=8 -> speed goes 3, 5, 7 ... 19, 20 and stays 20; night toggles every 8 frames; score counts 1 per frame.
- Collision and restart: collided=1 in the same cycle as a level boundary -> OVER, game_over=1, speed and night unchanged, slots frozen. Then start=1 -> RUN with slots cleared, score 0, speed 3, night 0.
